// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and frame geometry for the arbitrated UART transmitter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_W     = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, 0..BAUD_DIV-1 with a tick on the last count
//   clk_i  - clock
//   arst_i - asynchronous active-high reset
//   clr_i  - hold the count at zero
//   tick_o - high while the count equals BAUD_DIV-1 (bit boundary)
module uart_baud_cnt #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == CW'(BAUD_DIV - 1);

    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding a single 8N1 UART transmitter
//   clk_i            - clock
//   arst_i           - asynchronous active-high reset
//   req0_i, data0_i  - request and byte from requester 0
//   ack0_o           - one-cycle acceptance pulse to requester 0
//   req1_i, data1_i  - request and byte from requester 1
//   ack1_o           - one-cycle acceptance pulse to requester 1
//   tx_o             - serial line, idle high
//   busy_o           - high while a frame is in progress
//   grant_o          - requester owning the current or last frame
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              req0_i,
    input  logic [DATA_W-1:0] data0_i,
    output logic              ack0_o,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic              ack1_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              grant_o
);

    state_t            state_q, state_d;
    logic              tx_q, tx_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
    logic              tick;
    logic              win;

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    // Contested requests go to the requester not served last.
    assign win = (req0_i && req1_i) ? ~grant_q : req1_i;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        grant_d = grant_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:
                if (req0_i || req1_i) begin
                    state_d = START;
                    grant_d = win;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    shift_d = win ? data1_i : data0_i;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            START:
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            DATA:
                if (tick) begin
                    if (idx_q == 3'(DATA_W - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            STOP:
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 1'b1;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end

    assign tx_o    = tx_q;
    assign ack0_o  = ack0_q;
    assign ack1_o  = ack1_q;
    assign busy_o  = busy_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, framing and reset at BAUD_DIV=4
module tb_uart_tx_arbiter;

    logic       clk_i = 1'b0;
    logic       arst_i = 1'b0;
    logic       req0_i = 1'b0;
    logic [7:0] data0_i = 8'h00;
    logic       ack0_o;
    logic       req1_i = 1'b0;
    logic [7:0] data1_i = 8'h00;
    logic       ack1_o;
    logic       tx_o;
    logic       busy_o;
    logic       grant_o;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    uart_tx_arbiter #(.BAUD_DIV(4)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .req0_i (req0_i),
        .data0_i(data0_i),
        .ack0_o (ack0_o),
        .req1_i (req1_i),
        .data1_i(data1_i),
        .ack1_o (ack1_o),
        .tx_o   (tx_o),
        .busy_o (busy_o),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        arst_i = 1'b1;
        req0_i = 1'b0;
        req1_i = 1'b0;
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (!(ack0_o || ack1_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, 32'(ack0_o || ack1_o), 32'd1);
    endtask

    // Entered at the negedge of the first START cycle; leaves at the first IDLE cycle.
    task automatic frame_check(input logic [7:0] b, input string tag);
        logic e;
        for (int i = 0; i < 40; i++) begin
            e = (i < 4) ? 1'b0 : (i < 36) ? b[(i / 4) - 1] : 1'b1;
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx_o), 32'(e));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy_o), 32'd1);
            chk($sformatf("%s_ack%0d", tag, i), 32'(ack0_o || ack1_o), 32'(i == 0));
            @(negedge clk_i);
        end
        chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx_o), 32'd1);
    endtask

    initial begin
        int prev;
        logic seen;
        do_reset();
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ack0", 32'(ack0_o), 32'd0);
        chk("rst_ack1", 32'(ack1_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd1);

        req0_i = 1'b1;
        data0_i = 8'hA5;
        @(negedge clk_i);
        chk("a5_ack0", 32'(ack0_o), 32'd1);
        chk("a5_ack1", 32'(ack1_o), 32'd0);
        chk("a5_grant", 32'(grant_o), 32'd0);
        req0_i = 1'b0;
        frame_check(8'hA5, "a5");

        do_reset();
        req0_i = 1'b1;
        data0_i = 8'h3C;
        req1_i = 1'b1;
        data1_i = 8'hC3;
        @(negedge clk_i);
        chk("both_ack0", 32'(ack0_o), 32'd1);
        chk("both_ack1", 32'(ack1_o), 32'd0);
        req0_i = 1'b0;
        frame_check(8'h3C, "f3c");
        chk("both_idle_ack1", 32'(ack1_o), 32'd0);
        @(negedge clk_i);
        chk("both_second_ack1", 32'(ack1_o), 32'd1);
        chk("both_second_grant", 32'(grant_o), 32'd1);
        req1_i = 1'b0;
        frame_check(8'hC3, "fc3");

        do_reset();
        req0_i = 1'b1;
        req1_i = 1'b1;
        data0_i = 8'h11;
        data1_i = 8'h22;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("rr_wait%0d", k));
            chk($sformatf("rr_ack0_%0d", k), 32'(ack0_o), 32'(k % 2 == 0));
            chk($sformatf("rr_ack1_%0d", k), 32'(ack1_o), 32'(k % 2 == 1));
            chk($sformatf("rr_grant%0d", k), 32'(grant_o), 32'(k % 2));
            if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(cyc - prev), 32'd41);
            prev = cyc;
            @(negedge clk_i);
        end
        req0_i = 1'b0;
        req1_i = 1'b0;

        do_reset();
        req0_i = 1'b1;
        data0_i = 8'h5A;
        @(negedge clk_i);
        chk("mid_ack0", 32'(ack0_o), 32'd1);
        req0_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            req1_i = (i >= 10 && i < 15);
            @(negedge clk_i);
            seen |= ack1_o;
        end
        chk("mid_no_ack1", 32'(seen), 32'd0);
        chk("mid_tx_idle", 32'(tx_o), 32'd1);
        chk("mid_busy", 32'(busy_o), 32'd0);

        do_reset();
        req0_i = 1'b1;
        data0_i = 8'h96;
        @(negedge clk_i);
        chk("abort_ack0", 32'(ack0_o), 32'd1);
        req0_i = 1'b0;
        repeat (17) @(negedge clk_i);
        chk("abort_bit3_tx", 32'(tx_o), 32'd0);
        chk("abort_bit3_busy", 32'(busy_o), 32'd1);
        arst_i = 1'b1;
        #1;
        chk("abort_tx", 32'(tx_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        arst_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            seen |= ack0_o | ack1_o | ~tx_o;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        req0_i = 1'b1;
        data0_i = 8'h69;
        wait_ack("abort_next_wait");
        chk("abort_next_ack0", 32'(ack0_o), 32'd1);
        req0_i = 1'b0;
        frame_check(8'h69, "f69");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
